// File: rtl/alu16_pkg.sv
// Shared types and constants for the 16-bit datapath ALU.
// Function-select encoding, datapath width and flag bit positions.
package alu16_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    ALU_PASS_A = 2'b00,
    ALU_PASS_B = 2'b01,
    ALU_ADD    = 2'b10,
    ALU_SUB    = 2'b11
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu16_core.sv
// Combinational ALU function: pass A, pass B, add, subtract, with carry and signed overflow.
// Zero latency; carry/overflow are forced low for the pass functions.
module alu16_core
  import alu16_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [1:0]       alufs,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             is_sub;
  logic [ALU_W-1:0] b_eff;
  logic [ALU_W:0]   sum;

  // One shared adder: subtract is a + ~b + 1, so carry out of 1 means no borrow.
  always_comb begin
    is_sub = (alufs == ALU_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, is_sub};
  end

  always_comb begin
    result   = a;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_op_t'(alufs))
      ALU_PASS_A: result = a;
      ALU_PASS_B: result = b;
      ALU_ADD, ALU_SUB: begin
        result   = sum[ALU_W-1:0];
        carry    = sum[ALU_W];
        overflow = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
      end
    endcase
  end

endmodule

// File: rtl/alu_16.sv
// Registered 16-bit ALU, 1-cycle latency, loads every cycle (no handshake); sync active-high reset.
// Optional {N,Z,C,V} flags output compiled in with ALU16_FLAGS_EN.
module alu_16
  import alu16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  alufs,
  output logic [15:0] alu
`ifdef ALU16_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  logic [ALU_W-1:0] result;
  logic             carry;
  logic             overflow;

  alu16_core u_core (
    .a        (a),
    .b        (b),
    .alufs    (alufs),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) alu <= '0;
    else       alu <= result;
  end

`ifdef ALU16_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags[FLAG_N] <= result[ALU_W-1];
      flags[FLAG_Z] <= (result == '0);
      flags[FLAG_C] <= carry;
      flags[FLAG_V] <= overflow;
    end
  end
`else
  // Carry and overflow have no consumer without the flags register.
  logic unused_status;
  assign unused_status = carry ^ overflow;
`endif

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: directed test-plan vectors plus randomized traffic vs. an arithmetic model.
// Flag checks are active only when ALU16_FLAGS_EN is defined.
module tb_alu_16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic [1:0]  alufs;
  logic [15:0] alu;
`ifdef ALU16_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_16 dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .alufs (alufs),
    .alu   (alu)
`ifdef ALU16_FLAGS_EN
    ,
    .flags (flags)
`endif
  );

  // Returns {N, Z, C, V, result[15:0]} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] f);
    int unsigned ux = x;
    int unsigned uy = y;
    int          sx = $signed(x);
    int          sy = $signed(y);
    int unsigned r  = 0;
    int          sr = 0;
    bit          c  = 1'b0;
    bit          v  = 1'b0;
    case (f)
      2'd0: r = ux;
      2'd1: r = uy;
      2'd2: begin
        r  = ux + uy;
        c  = (r > 32'd65535);
        sr = sx + sy;
        v  = (sr > 32767) || (sr < -32768);
      end
      default: begin
        r  = (ux - uy) & 32'hFFFF;
        c  = (ux >= uy);
        sr = sx - sy;
        v  = (sr > 32767) || (sr < -32768);
      end
    endcase
    r = r & 32'hFFFF;
    return {r[15], (r == 0), c, v, r[15:0]};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [1:0] f,
                       input logic r);
    a = x; b = y; alufs = f; reset = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string nm, input logic [15:0] e_alu, input logic [3:0] e_flags);
    check({nm, "_alu"}, alu, e_alu);
`ifdef ALU16_FLAGS_EN
    check({nm, "_flags"}, {12'h0, flags}, {12'h0, e_flags});
`else
    if (e_flags === 4'bxxxx) $display("unexpected unknown flag expectation in %s", nm);
`endif
  endtask

  // Scoreboard: expected register contents derived at each rising edge, compared at the falling edge.
  logic [19:0] exp_q = '0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      exp_q <= '0;
      armed <= 1'b1;
    end else begin
      exp_q <= model(a, b, alufs);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_alu", alu, exp_q[15:0]);
`ifdef ALU16_FLAGS_EN
      check("model_flags", {12'h0, flags}, {12'h0, exp_q[19:16]});
`endif
    end
  end

  logic [19:0] pin;

  initial begin
    reset = 1'b1; a = '0; b = '0; alufs = 2'b00;
    @(posedge clk);
    @(negedge clk);
    expect_out("reset", 16'h0000, 4'b0000);

    drive(16'h0005, 16'h0003, 2'b10, 1'b0); expect_out("add_5_3",   16'h0008, 4'b0000);
    drive(16'h0008, 16'h0003, 2'b11, 1'b0); expect_out("sub_8_3",   16'h0005, 4'b0010);
    drive(16'h0008, 16'h0003, 2'b11, 1'b1); expect_out("mid_reset", 16'h0000, 4'b0000);
    drive(16'h0008, 16'h0003, 2'b11, 1'b0); expect_out("post_rst",  16'h0005, 4'b0010);
    drive(16'hFFFF, 16'h0001, 2'b10, 1'b0); expect_out("add_wrap",  16'h0000, 4'b0110);
    drive(16'h0000, 16'h0001, 2'b11, 1'b0); expect_out("sub_wrap",  16'hFFFF, 4'b1000);
    drive(16'h7FFF, 16'h0001, 2'b10, 1'b0); expect_out("add_ovf",   16'h8000, 4'b1001);
    drive(16'h1234, 16'hABCD, 2'b00, 1'b0); expect_out("pass_a",    16'h1234, 4'b0000);
    drive(16'h1234, 16'hABCD, 2'b01, 1'b0); expect_out("pass_b",    16'hABCD, 4'b1000);

    // Pin the model itself against hand-computed results.
    pin = model(16'h8000, 16'h0001, 2'b11);
    check("pin_sub_ovf", pin[15:0], 16'h7FFF);
    check("pin_sub_ovf_f", {12'h0, pin[19:16]}, 16'h0003);
    pin = model(16'hFFFF, 16'hFFFF, 2'b10);
    check("pin_add_neg", pin[15:0], 16'hFFFE);
    check("pin_add_neg_f", {12'h0, pin[19:16]}, 16'h000A);

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra, rb;
      logic [1:0]  rf;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) ra = 16'h8000;
      if ($urandom_range(7) == 0) rb = ra;
      drive(ra, rb, rf, ($urandom_range(15) == 0));
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
